// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC with stall/redirect plus a circular prefetch queue feeding decode.
// Fetch-to-decode latency 1 cycle; decode stalls via out_ready, fetch continues until the queue is full.
module fetch_unit #(
  parameter int ADDR_LEN    = 12,
  parameter int INSTR_LEN   = 19,
  parameter int QUEUE_DEPTH = 2,
  parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADDR_LEN-1:0]  imem_addr,
  input  logic [INSTR_LEN-1:0] imem_data,
  input  logic                 redirect_valid,
  input  logic [ADDR_LEN-1:0]  redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_LEN-1:0] out_instruction,
  output logic [ADDR_LEN-1:0]  out_pc_plus1
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [INSTR_LEN-1:0] instr;
    logic [ADDR_LEN-1:0]  pc_plus1;
  } entry_t;

  entry_t               queue [QUEUE_DEPTH];
  entry_t               head_entry;
  logic [ADDR_LEN-1:0]  pc;
  logic [ADDR_LEN-1:0]  pc_plus1;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W-1:0]     head_next;
  logic [PTR_W-1:0]     tail_next;
  logic [CNT_W-1:0]     count;
  logic                 deq;
  logic                 fetch;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pc_plus1   = pc + ADDR_LEN'(1);
    head_next  = ptr_inc(head);
    tail_next  = ptr_inc(tail);
    head_entry = queue[head];
    out_valid  = (count != '0) & ~redirect_valid;
    deq        = out_valid & out_ready;
    // A full queue still accepts a new entry when the head leaves in the same cycle.
    fetch      = ~redirect_valid & ((count < CNT_W'(QUEUE_DEPTH)) | deq);
    out_instruction = out_valid ? head_entry.instr    : '0;
    out_pc_plus1    = out_valid ? head_entry.pc_plus1 : '0;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= RESET_PC;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      count <= '0;
      head  <= tail;
    end else begin
      if (fetch) begin
        pc   <= pc_plus1;
        tail <= tail_next;
      end
      if (deq) head <= head_next;
      if (fetch && !deq)      count <= count + CNT_W'(1);
      else if (deq && !fetch) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && fetch) queue[tail] <= '{instr: imem_data, pc_plus1: pc_plus1};
  end

endmodule
